// File: rtl/clock_pkg.sv
// Shared types and sizing helpers for the time-slice arbiter.
// Holds the arbiter state encoding and the slice-counter width.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SWITCH = 2'd2
    } arb_state_e;

    // The counter must hold 0..slice, hence slice+1 distinct values.
    function automatic int time_width(input int slice);
        return (slice < 1) ? 1 : $clog2(slice + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo the number of requesters.
module rr_pick #(
    parameter int p_req = 4
) (
    input  logic [p_req-1:0]         req,
    input  logic [$clog2(p_req)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(p_req)-1:0] sel
);

    always_comb begin
        int idx;
        valid = 1'b0;
        sel   = '0;
        for (int i = 0; i < p_req; i++) begin
            idx = int'(ptr) + i;
            if (idx >= p_req) begin
                idx = idx - p_req;
            end
            if (!valid && req[idx]) begin
                valid = 1'b1;
                sel   = ($clog2(p_req))'(idx);
            end
        end
    end

endmodule

// File: rtl/slice_arbiter.sv
// Time-slice round-robin arbiter: one grantee at a time, released voluntarily
// or after p_slice counted (non-hold) cycles, with all outputs registered.
module slice_arbiter
    import clock_pkg::*;
#(
    parameter int p_req   = 4,
    parameter int p_slice = 5
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [p_req-1:0]                   i_req,
    input  logic                               i_hold,
    output logic [p_req-1:0]                   o_grant,
    output logic [$clog2(p_req)-1:0]           o_grant_id,
    output logic                               o_valid,
    output logic [time_width(p_slice)-1:0]     o_time,
    output logic                               o_slice_end
);

    localparam int ID_W = $clog2(p_req);
    localparam int T_W  = time_width(p_slice);

    arb_state_e        state_q, state_d;
    logic [p_req-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              valid_q, valid_d;
    logic [T_W-1:0]    time_q, time_d;
    logic              slice_end_q, slice_end_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic              pick_valid;
    logic [ID_W-1:0]   pick_sel;
    logic [ID_W-1:0]   next_ptr;

    rr_pick #(.p_req(p_req)) u_pick (
        .req   (i_req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    assign next_ptr = (grant_id_q == ID_W'(p_req - 1)) ? '0 : grant_id_q + 1'b1;

    // Release is checked before hold and expiry so a dropped request always wins.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        valid_d     = valid_q;
        time_d      = time_q;
        slice_end_d = 1'b0;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                time_d  = '0;
                if (pick_valid) begin
                    state_d    = GRANT;
                    grant_d    = {{(p_req-1){1'b0}}, 1'b1} << pick_sel;
                    grant_id_d = pick_sel;
                    valid_d    = 1'b1;
                end
            end
            GRANT: begin
                if (!i_req[grant_id_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    time_d  = '0;
                    ptr_d   = next_ptr;
                end else if (i_hold) begin
                    time_d = time_q;
                end else if (time_q == T_W'(p_slice - 1)) begin
                    state_d     = SWITCH;
                    grant_d     = '0;
                    valid_d     = 1'b0;
                    time_d      = '0;
                    slice_end_d = 1'b1;
                    ptr_d       = next_ptr;
                end else begin
                    time_d = time_q + 1'b1;
                end
            end
            SWITCH: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                time_d  = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                time_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            valid_q     <= 1'b0;
            time_q      <= '0;
            slice_end_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            valid_q     <= valid_d;
            time_q      <= time_d;
            slice_end_q <= slice_end_d;
            ptr_q       <= ptr_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_grant_id  = grant_id_q;
    assign o_valid     = valid_q;
    assign o_time      = time_q;
    assign o_slice_end = slice_end_q;

endmodule

// File: doc/slice_arbiter.md
Name: slice_arbiter

Overview:
Time-slice round-robin arbiter that shares one timed resource (bus, execution slot) between p_req requesters. Each grant lasts until the requester releases it or until its slice of p_slice counted cycles expires. Slice counting can be frozen by i_hold, in the same way a stop input freezes a timer. It sits in the clock subsystem between the requesting units and the shared resource.

Parameters:
p_req, 4, number of requesters (2..16)
p_slice, 5, slice length in counted cycles (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_req  in  p_req  request per requester, level, held while the resource is needed
i_hold  in  1  freezes the slice counter while high; the grant is kept
o_grant  out  p_req  one-hot grant, registered
o_grant_id  out  $clog2(p_req)  index of the current/last grantee, registered
o_valid  out  1  high while any grant is active (equals |o_grant)
o_time  out  $clog2(p_slice+1)  counted cycles elapsed in the current slice; 0 when no grant is active
o_slice_end  out  1  one-cycle pulse when a slice expires (not on voluntary release)

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: o_grant=0, o_grant_id=0, o_valid=0, o_time=0, o_slice_end=0, rr pointer=0, state=IDLE. Reset mid-grant drops the grant on the next edge; no o_slice_end is produced.
- States: IDLE, GRANT, SWITCH. All outputs are registered.
- IDLE: if |i_req, select the first requester at or after the rr pointer, wrapping modulo p_req. Next state is GRANT, o_grant=onehot(sel), o_grant_id=sel, o_time=0. If there is no request, stay in IDLE.
- Grant latency: a request sampled in IDLE produces o_grant high from the next cycle.
- GRANT, checks in priority order:
  1. i_req[id]==0: release. Next state IDLE, grant cleared, pointer=id+1 mod p_req, o_time=0, no pulse.
  2. i_hold==1: hold everything, o_time unchanged.
  3. o_time==p_slice-1: expiry. Next state SWITCH, grant cleared, o_slice_end=1, pointer=id+1 mod p_req, o_time=0.
  4. Otherwise o_time increments by 1.
- A granted requester therefore holds the resource for exactly p_slice non-hold cycles on expiry.
- SWITCH: lasts one cycle with o_slice_end high and o_valid low. Next state is always IDLE, and o_slice_end returns low.
- Gaps between grants: release leaves 1 idle cycle before the next grant; expiry leaves 2 (SWITCH, then IDLE).
- A single persistent requester is re-granted after expiry because the pointer wraps around to it.
- Requests from non-granted requesters do not affect the current grant.
- Requests may drop while waiting; only requests sampled in IDLE count.
- Simultaneous release and expiry: release wins, no o_slice_end.
- Simultaneous hold and release: release wins.
- o_grant_id keeps its last value in IDLE/SWITCH; o_grant=0 there.
- Unreachable state encodings go to IDLE with the grant cleared.

Decomposition:
- Package clock_pkg: typedef enum logic[1:0] for the states {IDLE, GRANT, SWITCH}, and a width helper for $clog2(p_slice+1).
- Sub-module rr_pick (combinational): inputs req vector and pointer; outputs the valid flag and the selected index.
- slice_arbiter contains the FSM, slice counter and pointer.

Test Plan:
- Reset with i_req=4'b1111 -> next edge grants id 0; o_time counts 0..4; o_slice_end pulses at cycle 6; grants then follow in order 1, 2, 3, 0.
- i_req=4'b0100 only, p_slice=5 -> grant 2 for 5 cycles, then SWITCH, then IDLE, then grant 2 again; repeats with a 2-cycle gap each time.
- Grant 1 active with o_time=2, drop i_req[1] -> next cycle o_grant=0, o_slice_end stays 0, pointer=2; if i_req[3] is high, the next grant is 3.
- i_hold high for 3 cycles at o_time=1 -> o_time stays 1; expiry is delayed by 3 cycles, giving 8 total grant cycles.
- Drop i_req[id] exactly when o_time=4 (expiry cycle) -> release path taken, no o_slice_end; also assert i_rst mid-grant -> all outputs 0 on the next edge.
